instr_register_pipe: RTL and testbench

// - Parametrised successor of the lab instruction register: DEPTH-entry store of {opc, op_a, op_b, res}.
// - Result is computed in a registered 2-stage write pipeline and written back with the operands.
// - Adds per-entry valid bits, a loaded-entry counter and sticky error flags.
// - Sits between the stimulus/test driver and the checker, which reads entries back by pointer.

---
 rtl/instr_register_pkg.sv | 30 +++
 rtl/instr_register_pipe_alu.sv | 78 +++++++
 rtl/instr_register_pipe.sv | 232 +++++++++++++++++++++++
 tb/tb_instr_register_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// -----------------------------------------------------------------------------
// instr_register_pkg
// Shared definitions for the pipelined instruction register:
//   - opcode_t     : 4-bit opcode encoding ZERO..MOD (values 8..15 are illegal)
//   - DEF_*        : default widths and depth used by the top-level parameters
//   - is_legal_op(): true for opcodes that have a defined operation
// -----------------------------------------------------------------------------
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  localparam int DEF_OP_W  = 32;
  localparam int DEF_RES_W = 64;
  localparam int DEF_DEPTH = 32;

  // Only the lower half of the 4-bit opcode space carries a defined operation.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/instr_register_pipe_alu.sv
// -----------------------------------------------------------------------------
// instr_alu
// Combinational ALU used in the second write-pipeline stage.
// Both operands are sign-extended to RES_W before any operation, so ADD/SUB
// cannot overflow and MULT yields the full signed product.
// Ports:
//   opc_i       raw 4-bit opcode (may be illegal, 8..15)
//   a_i, b_i    signed operands, OP_W bits
//   res_o       signed result, RES_W bits
//   opc_o       opcode to store (ZERO for illegal opcodes)
//   div_zero_o  DIV or MOD attempted with b == 0
//   illegal_o   opcode outside the defined set
// -----------------------------------------------------------------------------
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_W  = DEF_OP_W,
  parameter int RES_W = DEF_RES_W
) (
  input  logic        [3:0]       opc_i,
  input  logic signed [OP_W-1:0]  a_i,
  input  logic signed [OP_W-1:0]  b_i,
  output logic signed [RES_W-1:0] res_o,
  output opcode_t                 opc_o,
  output logic                    div_zero_o,
  output logic                    illegal_o
);

  logic signed [RES_W-1:0] a_ext_s;
  logic signed [RES_W-1:0] b_ext_s;
  logic signed [RES_W-1:0] b_safe_s;
  logic                    b_zero_s;

  assign a_ext_s  = {{(RES_W-OP_W){a_i[OP_W-1]}}, a_i};
  assign b_ext_s  = {{(RES_W-OP_W){b_i[OP_W-1]}}, b_i};
  assign b_zero_s = (b_i == {OP_W{1'b0}});
  // The divider never sees a zero divisor; the b==0 result is forced to 0 below.
  assign b_safe_s = b_zero_s ? {{(RES_W-1){1'b0}}, 1'b1} : b_ext_s;

  // Operation select; SV signed '/' truncates toward zero and '%' follows the sign of a.
  always_comb begin
    res_o      = {RES_W{1'b0}};
    opc_o      = ZERO;
    div_zero_o = 1'b0;
    illegal_o  = 1'b0;
    if (is_legal_op(opc_i)) begin
      opc_o = opcode_t'(opc_i);
      case (opcode_t'(opc_i))
        ZERO:    res_o = {RES_W{1'b0}};
        PASSA:   res_o = a_ext_s;
        PASSB:   res_o = b_ext_s;
        ADD:     res_o = a_ext_s + b_ext_s;
        SUB:     res_o = a_ext_s - b_ext_s;
        MULT:    res_o = a_ext_s * b_ext_s;
        DIV: begin
          if (b_zero_s) begin
            res_o      = {RES_W{1'b0}};
            div_zero_o = 1'b1;
          end else begin
            res_o      = a_ext_s / b_safe_s;
          end
        end
        MOD: begin
          if (b_zero_s) begin
            res_o      = {RES_W{1'b0}};
            div_zero_o = 1'b1;
          end else begin
            res_o      = a_ext_s % b_safe_s;
          end
        end
        default: res_o = {RES_W{1'b0}};
      endcase
    end else begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/instr_register_pipe.sv
// -----------------------------------------------------------------------------
// instr_register_pipe
// DEPTH-entry instruction store of {opc, op_a, op_b, res}. A load passes through
// a two-stage registered pipeline (S1: capture, S2: ALU result) and is written
// back two clocks after it is accepted. One load per cycle, no back-pressure,
// no read forwarding.
// Optional feature (macro INSTR_REG_PARITY_EN): per-entry even parity with a
// combinational parity_err output and a test-only inject_perr input.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   load_en                accept one instruction this cycle
//   opcode                 4-bit opcode (opcode_t encoding, 8..15 illegal)
//   operand_a, operand_b   signed operands
//   write_pointer          destination entry
//   read_pointer           entry presented on instruction_word / rd_valid
//   clr_flags              synchronous clear of the sticky flags (a set wins)
//   instruction_word       packed {opc[3:0], op_a, op_b, res}, opc in the MSBs
//   rd_valid               entry at read_pointer written since reset
//   num_loaded             number of valid entries, 0..DEPTH
//   div_zero_flag          sticky: DIV/MOD written back with b == 0
//   illegal_op_flag        sticky: illegal opcode written back
//   inject_perr            (parity build) store inverted parity on writeback
//   parity_err             (parity build) stored parity mismatch at read_pointer
// -----------------------------------------------------------------------------
module instr_register_pipe
  import instr_register_pkg::*;
#(
  parameter  int OP_W    = DEF_OP_W,
  parameter  int RES_W   = 2*OP_W,
  parameter  int DEPTH   = DEF_DEPTH,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int INSTR_W = 4 + 2*OP_W + RES_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_en,
  input  logic [3:0]               opcode,
  input  logic signed [OP_W-1:0]   operand_a,
  input  logic signed [OP_W-1:0]   operand_b,
  input  logic [ADDR_W-1:0]        write_pointer,
  input  logic [ADDR_W-1:0]        read_pointer,
  input  logic                     clr_flags,
`ifdef INSTR_REG_PARITY_EN
  input  logic                     inject_perr,
  output logic                     parity_err,
`endif
  output logic [INSTR_W-1:0]       instruction_word,
  output logic                     rd_valid,
  output logic [ADDR_W:0]          num_loaded,
  output logic                     div_zero_flag,
  output logic                     illegal_op_flag
);

  // Package types cannot be parametrised, so the entry layout lives here.
  typedef struct packed {
    opcode_t                 opc;
    logic signed [OP_W-1:0]  op_a;
    logic signed [OP_W-1:0]  op_b;
    logic signed [RES_W-1:0] res;
  } instr_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  // Stage 1 registers
  logic                    s1_valid_q;
  logic [3:0]              s1_opc_q;
  logic signed [OP_W-1:0]  s1_a_q;
  logic signed [OP_W-1:0]  s1_b_q;
  logic [ADDR_W-1:0]       s1_ptr_q;

  // Stage 2 registers
  logic                    s2_valid_q;
  logic [ADDR_W-1:0]       s2_ptr_q;
  instr_t                  s2_word_q;
  instr_t                  s2_word_d;
  logic                    s2_dz_q;
  logic                    s2_ill_q;

  // Storage and status
  instr_t                  mem_q [DEPTH];
  logic [DEPTH-1:0]        valid_q;
  logic [ADDR_W:0]         num_loaded_q;
  logic [ADDR_W:0]         num_loaded_d;
  logic                    dz_flag_q;
  logic                    dz_flag_d;
  logic                    ill_flag_q;
  logic                    ill_flag_d;

  // ALU outputs
  logic signed [RES_W-1:0] alu_res_s;
  opcode_t                 alu_opc_s;
  logic                    alu_dz_s;
  logic                    alu_ill_s;

  instr_alu #(
    .OP_W  (OP_W),
    .RES_W (RES_W)
  ) u_alu (
    .opc_i      (s1_opc_q),
    .a_i        (s1_a_q),
    .b_i        (s1_b_q),
    .res_o      (alu_res_s),
    .opc_o      (alu_opc_s),
    .div_zero_o (alu_dz_s),
    .illegal_o  (alu_ill_s)
  );

  // Stage 1: capture the incoming instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_opc_q   <= 4'd0;
      s1_a_q     <= {OP_W{1'b0}};
      s1_b_q     <= {OP_W{1'b0}};
      s1_ptr_q   <= {ADDR_W{1'b0}};
    end else begin
      s1_valid_q <= load_en;
      s1_opc_q   <= opcode;
      s1_a_q     <= operand_a;
      s1_b_q     <= operand_b;
      s1_ptr_q   <= write_pointer;
    end
  end

  // Assemble the entry that stage 2 will hold.
  always_comb begin
    s2_word_d      = '0;
    s2_word_d.opc  = alu_opc_s;
    s2_word_d.op_a = s1_a_q;
    s2_word_d.op_b = s1_b_q;
    s2_word_d.res  = alu_res_s;
  end

  // Stage 2: register the ALU result and the write target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_ptr_q   <= {ADDR_W{1'b0}};
      s2_word_q  <= '0;
      s2_dz_q    <= 1'b0;
      s2_ill_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_ptr_q   <= s1_ptr_q;
      s2_word_q  <= s2_word_d;
      s2_dz_q    <= s1_valid_q & alu_dz_s;
      s2_ill_q   <= s1_valid_q & alu_ill_s;
    end
  end

  // Writeback into the entry array and its valid bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= {DEPTH{1'b0}};
    end else if (s2_valid_q) begin
      mem_q[s2_ptr_q]   <= s2_word_q;
      valid_q[s2_ptr_q] <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Count only first-time writes of an entry; never exceed DEPTH.
  always_comb begin
    num_loaded_d = num_loaded_q;
    if (s2_valid_q && !valid_q[s2_ptr_q] && (num_loaded_q != FULL_CNT)) begin
      num_loaded_d = num_loaded_q + {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      num_loaded_d = num_loaded_q;
    end
  end

  // Sticky flags: clear first, then a writeback that raises a flag overrides it.
  always_comb begin
    dz_flag_d  = clr_flags ? 1'b0 : dz_flag_q;
    ill_flag_d = clr_flags ? 1'b0 : ill_flag_q;
    if (s2_valid_q && s2_dz_q) begin
      dz_flag_d = 1'b1;
    end else begin
      dz_flag_d = dz_flag_d;
    end
    if (s2_valid_q && s2_ill_q) begin
      ill_flag_d = 1'b1;
    end else begin
      ill_flag_d = ill_flag_d;
    end
  end

  // Status registers: loaded-entry count and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_loaded_q <= {(ADDR_W+1){1'b0}};
      dz_flag_q    <= 1'b0;
      ill_flag_q   <= 1'b0;
    end else begin
      num_loaded_q <= num_loaded_d;
      dz_flag_q    <= dz_flag_d;
      ill_flag_q   <= ill_flag_d;
    end
  end

  assign instruction_word = mem_q[read_pointer];
  assign rd_valid         = valid_q[read_pointer];
  assign num_loaded       = num_loaded_q;
  assign div_zero_flag    = dz_flag_q;
  assign illegal_op_flag  = ill_flag_q;

`ifdef INSTR_REG_PARITY_EN
  logic [DEPTH-1:0] par_q;

  function automatic logic even_parity(input instr_t w);
    return ^w;
  endfunction

  // Parity bit per entry; the reset value matches an all-zero entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q <= {DEPTH{1'b0}};
    end else if (s2_valid_q) begin
      par_q[s2_ptr_q] <= even_parity(s2_word_q) ^ inject_perr;
    end else begin
      par_q <= par_q;
    end
  end

  assign parity_err = even_parity(mem_q[read_pointer]) ^ par_q[read_pointer];
`endif

endmodule

// File: tb/tb_instr_register_pipe.sv
// -----------------------------------------------------------------------------
// tb_instr_register_pipe
// Self-checking bench for instr_register_pipe (default parameters).
// Loads are pushed to a scoreboard queue when driven and popped at the
// writeback edge, where the entry, valid bit, count and flags are compared
// against a small reference model of the store.
// -----------------------------------------------------------------------------
module tb_instr_register_pipe;

  localparam int OP_W   = 32;
  localparam int RES_W  = 64;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int IW     = 4 + 2*OP_W + RES_W;

  logic                    clk;
  logic                    reset_n;
  logic                    load_en;
  logic [3:0]              opcode;
  logic signed [OP_W-1:0]  operand_a;
  logic signed [OP_W-1:0]  operand_b;
  logic [ADDR_W-1:0]       write_pointer;
  logic [ADDR_W-1:0]       read_pointer;
  logic                    clr_flags;
  logic [IW-1:0]           instruction_word;
  logic                    rd_valid;
  logic [ADDR_W:0]         num_loaded;
  logic                    div_zero_flag;
  logic                    illegal_op_flag;
`ifdef INSTR_REG_PARITY_EN
  logic                    inject_perr;
  logic                    parity_err;
`endif

  instr_register_pipe dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_en          (load_en),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .clr_flags        (clr_flags),
`ifdef INSTR_REG_PARITY_EN
    .inject_perr      (inject_perr),
    .parity_err       (parity_err),
`endif
    .instruction_word (instruction_word),
    .rd_valid         (rd_valid),
    .num_loaded       (num_loaded),
    .div_zero_flag    (div_zero_flag),
    .illegal_op_flag  (illegal_op_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]        opc;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [ADDR_W-1:0] ptr;
    logic [3:0]        exp_opc;
    logic [RES_W-1:0]  exp_res;
    logic              exp_dz;
    logic              exp_ill;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] ptr;
    logic [IW-1:0]     word;
    logic              dz;
    logic              ill;
  } sb_t;

  vec_t          vecs [12];
  sb_t           sbq [$];
  logic [IW-1:0] model_mem [DEPTH];
  logic          model_valid [DEPTH];
  int            model_cnt;
  logic          model_dz;
  logic          model_ill;
  int            checks;
  int            errors;

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] mk(input logic [3:0] o, input logic [OP_W-1:0] a,
                                       input logic [OP_W-1:0] b, input logic [RES_W-1:0] r);
    return {o, a, b, r};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = '0;
      model_valid[i] = 1'b0;
    end
    model_cnt = 0;
    model_dz  = 1'b0;
    model_ill = 1'b0;
    sbq.delete();
  endtask

  // Drive one load for the coming edge and record what it must produce.
  task automatic issue(input logic [3:0] opc, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                       input logic [ADDR_W-1:0] ptr, input logic [3:0] eopc,
                       input logic [RES_W-1:0] eres, input logic edz, input logic eill);
    sb_t e;
    load_en       = 1'b1;
    opcode        = opc;
    operand_a     = a;
    operand_b     = b;
    write_pointer = ptr;
    e.ptr  = ptr;
    e.word = mk(eopc, a, b, eres);
    e.dz   = edz;
    e.ill  = eill;
    sbq.push_back(e);
  endtask

  // Called just after a writeback edge: pop the oldest load and compare.
  task automatic retire(input string name, input logic clr);
    sb_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sbq.pop_front();
      if (clr) begin
        model_dz  = 1'b0;
        model_ill = 1'b0;
      end
      if (!model_valid[e.ptr] && model_cnt < DEPTH) model_cnt++;
      model_valid[e.ptr] = 1'b1;
      model_mem[e.ptr]   = e.word;
      if (e.dz)  model_dz  = 1'b1;
      if (e.ill) model_ill = 1'b1;
      read_pointer = e.ptr;
      #1;
      chk({name, " word"},   instruction_word,    model_mem[e.ptr]);
      chk({name, " valid"},  IW'(rd_valid),       IW'(1'b1));
      chk({name, " count"},  IW'(num_loaded),     IW'(model_cnt));
      chk({name, " dzflag"}, IW'(div_zero_flag),  IW'(model_dz));
      chk({name, " ilflag"}, IW'(illegal_op_flag), IW'(model_ill));
`ifdef INSTR_REG_PARITY_EN
      chk({name, " perr"},   IW'(parity_err),     IW'(1'b0));
`endif
    end
  endtask

  // Entry at ptr must still show its pre-load contents.
  task automatic chk_old(input string name, input logic [ADDR_W-1:0] ptr);
    read_pointer = ptr;
    #1;
    chk({name, " oldword"},  instruction_word, model_mem[ptr]);
    chk({name, " oldvalid"}, IW'(rd_valid),    IW'(model_valid[ptr]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    load_en       = 1'b0;
    opcode        = 4'd0;
    operand_a     = '0;
    operand_b     = '0;
    write_pointer = '0;
    read_pointer  = '0;
    clr_flags     = 1'b0;
`ifdef INSTR_REG_PARITY_EN
    inject_perr   = 1'b0;
`endif
    model_reset();

    //               opc    a             b             ptr    eopc   eres                    dz    ill
    vecs[0]  = '{4'h3, 32'h0000_0005, 32'hFFFF_FFF9, 5'd3,  4'h3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[1]  = '{4'h5, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 5'd0,  4'h5, 64'hFFFF_FFFF_0000_0002, 1'b0, 1'b0};
    vecs[2]  = '{4'h6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  4'h6, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
    vecs[3]  = '{4'h7, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  4'h7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[4]  = '{4'h1, 32'h0000_007B, 32'h0000_0009, 5'd6,  4'h1, 64'h0000_0000_0000_007B, 1'b0, 1'b0};
    vecs[5]  = '{4'h2, 32'h0000_0001, 32'hFFFF_FFF7, 5'd7,  4'h2, 64'hFFFF_FFFF_FFFF_FFF7, 1'b0, 1'b0};
    vecs[6]  = '{4'h4, 32'h8000_0000, 32'h0000_0001, 5'd8,  4'h4, 64'hFFFF_FFFF_7FFF_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{4'h0, 32'h0000_0004, 32'h0000_0005, 5'd9,  4'h0, 64'h0000_0000_0000_0000, 1'b0, 1'b0};
    vecs[8]  = '{4'h6, 32'h0000_0009, 32'h0000_0000, 5'd10, 4'h6, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{4'hC, 32'h0000_0003, 32'h0000_0004, 5'd11, 4'h0, 64'h0000_0000_0000_0000, 1'b0, 1'b1};
    vecs[10] = '{4'h7, 32'h0000_0007, 32'hFFFF_FFFE, 5'd12, 4'h7, 64'h0000_0000_0000_0001, 1'b0, 1'b0};
    vecs[11] = '{4'h3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd13, 4'h3, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    for (int p = 0; p < DEPTH; p += 7) begin
      chk_old("reset", 5'(p));
    end
    chk("reset count",  IW'(num_loaded),      IW'(0));
    chk("reset dzflag", IW'(div_zero_flag),   IW'(1'b0));
    chk("reset ilflag", IW'(illegal_op_flag), IW'(1'b0));

    // Table: each load checked at N (old), N+1 (old) and N+2 (written)
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].ptr,
            vecs[i].exp_opc, vecs[i].exp_res, vecs[i].exp_dz, vecs[i].exp_ill);
      tick();
      load_en = 1'b0;
      chk_old($sformatf("vec%0d@N", i), vecs[i].ptr);
      tick();
      chk_old($sformatf("vec%0d@N+1", i), vecs[i].ptr);
      tick();
      retire($sformatf("vec%0d", i), 1'b0);
    end

    // clr_flags on the same edge as a new divide-by-zero writeback
    issue(4'h6, 32'd9, 32'd0, 5'd14, 4'h6, 64'd0, 1'b1, 1'b0);
    tick();
    load_en = 1'b0;
    tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    retire("clr+set", 1'b1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    model_dz  = 1'b0;
    model_ill = 1'b0;
    chk("clr dzflag", IW'(div_zero_flag),   IW'(model_dz));
    chk("clr ilflag", IW'(illegal_op_flag), IW'(model_ill));

    // Fill every entry back-to-back; retire each two edges after its capture
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (k < DEPTH) begin
        issue(4'h1, 32'(100 + k), 32'(k), 5'(k), 4'h1, 64'(100 + k), 1'b0, 1'b0);
      end else begin
        load_en = 1'b0;
      end
      tick();
      if (k >= 2) retire($sformatf("fill%0d", k - 2), 1'b0);
    end
    chk("full count", IW'(num_loaded), IW'(DEPTH));

    // Back-to-back rewrites of ptr 1: the later write lands one cycle later and wins
    issue(4'h3, 32'd1, 32'd1, 5'd1, 4'h3, 64'd2, 1'b0, 1'b0);
    tick();
    issue(4'h4, 32'd1, 32'd1, 5'd1, 4'h4, 64'd0, 1'b0, 1'b0);
    tick();
    load_en = 1'b0;
    tick();
    retire("rewrite1", 1'b0);
    tick();
    retire("rewrite2", 1'b0);
    chk("rewrite count", IW'(num_loaded), IW'(DEPTH));

    // Reset with two writes in flight
    issue(4'h3, 32'd5, 32'd5, 5'd20, 4'h3, 64'd10, 1'b0, 1'b0);
    tick();
    issue(4'h3, 32'd6, 32'd6, 5'd21, 4'h3, 64'd12, 1'b0, 1'b0);
    tick();
    load_en = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int p = 0; p < DEPTH; p++) begin
      chk_old($sformatf("midrst%0d", p), 5'(p));
    end
    chk("midrst count",  IW'(num_loaded),      IW'(0));
    chk("midrst dzflag", IW'(div_zero_flag),   IW'(1'b0));
    chk("midrst ilflag", IW'(illegal_op_flag), IW'(1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk_old("postrst20", 5'd20);
    chk_old("postrst21", 5'd21);
    chk("postrst count", IW'(num_loaded), IW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
